binary_search_engine: RTL and testbench

Parametrised binary-search engine that searches a sorted (ascending, unsigned) memory for a target value, in either exact-match or lower-bound mode, over a caller-selected index window. It owns the whole search: a registered control FSM plus the L/R/mid datapath. It drives a synchronous-read memory port of configurable read latency and reports the result through a start/done handshake. It generalises the fixed 8-bit / 32-entry / single-cycle-read searcher.

---
 rtl/binary_search_pkg.sv | 20 ++
 rtl/binary_search_engine_ctrl.sv | 75 +++++++
 rtl/binary_search_engine_datapath.sv | 130 +++++++++++++
 rtl/binary_search_engine.sv | 65 ++++++
 tb/tb_binary_search_engine.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/binary_search_pkg.sv
// Shared types and constants for the binary-search engine.
package binary_search_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMPUTE = 3'd1,
    FETCH   = 3'd2,
    WAIT    = 3'd3,
    DECIDE  = 3'd4,
    RESOLVE = 3'd5,
    DONE    = 3'd6
  } state_e;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_LBOUND = 1'b1;

  // Wide enough for RD_LAT-2 with RD_LAT up to 8.
  localparam int unsigned WAIT_CNT_W = 3;

endpackage

// File: rtl/binary_search_engine_ctrl.sv
// Search sequencer: state register, read-latency wait counter, handshake strobes.
module binary_search_engine_ctrl
  import binary_search_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   start,
  input  logic   l_gt_r_c,
  input  logic   exact_hit_c,
  output state_e state,
  output logic   ready,
  output logic   done,
  output logic   mem_rd
);

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
  logic                    mem_rd_q, mem_rd_d;

  // Next state, wait counter and registered strobes derived from the next state.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE:    if (start) state_d = COMPUTE;
      COMPUTE: state_d = l_gt_r_c ? RESOLVE : FETCH;
      FETCH: begin
        if (RD_LAT == 1) begin
          state_d = DECIDE;
        end else begin
          state_d    = WAIT;
          wait_cnt_d = WAIT_CNT_W'(RD_LAT - 2);
        end
      end
      WAIT: begin
        if (wait_cnt_q == '0) state_d = DECIDE;
        else                  wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
      end
      DECIDE:  state_d = exact_hit_c ? DONE : COMPUTE;
      RESOLVE: state_d = DONE;
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d  = (state_d == IDLE);
    done_d   = (state_d == DONE);
    mem_rd_d = (state_d == FETCH);
  end

  // State and strobe registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      mem_rd_q   <= mem_rd_d;
    end
  end

  assign state  = state_q;
  assign ready  = ready_q;
  assign done   = done_q;
  assign mem_rd = mem_rd_q;

endmodule

// File: rtl/binary_search_engine_datapath.sv
// Search window bounds, probe address and result registers.
module binary_search_engine_datapath
  import binary_search_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  state_e            state,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] target,
  input  logic [ADDR_W-1:0] lo,
  input  logic [ADDR_W-1:0] hi,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              l_gt_r_c,
  output logic              exact_hit_c,
  output logic              found,
  output logic [ADDR_W-1:0] index,
  output logic [ADDR_W:0]   steps,
  output logic [ADDR_W-1:0] mem_addr
);

  localparam int unsigned PW = ADDR_W + 1;

  logic signed [PW-1:0]   l_q, l_d, r_q, r_d;
  logic [ADDR_W-1:0]      hi_q, hi_d;
  logic [DATA_W-1:0]      target_q, target_d;
  logic                   mode_q, mode_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic                   found_q, found_d;
  logic [ADDR_W-1:0]      index_q, index_d;
  logic [PW-1:0]          steps_q, steps_d;

  // L only ever grows from a non-negative start and may reach 2**ADDR_W, which
  // overflows the signed range; compare one bit wider with L zero-extended.
  logic signed [PW:0]     l_ext, r_ext;
  logic signed [PW-1:0]   mid_c;
  logic [PW-1:0]          addr_ext;
  logic                   lb_found_c;

  assign l_ext       = $signed({1'b0, l_q});
  assign r_ext       = $signed({r_q[PW-1], r_q});
  assign l_gt_r_c    = (l_ext > r_ext);
  assign mid_c       = l_q + ((r_q - l_q) >>> 1);
  assign addr_ext    = {1'b0, mem_addr_q};
  assign exact_hit_c = (mode_q == MODE_EXACT) && (mem_rdata == target_q);
  assign lb_found_c  = ($unsigned(l_ext) <= {2'b00, hi_q});

  // Per-state datapath updates; both modes share the narrowing rule off-equality.
  always_comb begin
    l_d        = l_q;
    r_d        = r_q;
    hi_d       = hi_q;
    target_d   = target_q;
    mode_d     = mode_q;
    mem_addr_d = mem_addr_q;
    found_d    = found_q;
    index_d    = index_q;
    steps_d    = steps_q;
    case (state)
      IDLE: begin
        if (start) begin
          target_d = target;
          mode_d   = mode;
          hi_d     = hi;
          l_d      = $signed({1'b0, lo});
          r_d      = $signed({1'b0, hi});
          found_d  = 1'b0;
          index_d  = '0;
          steps_d  = '0;
        end
      end
      COMPUTE: if (!l_gt_r_c) mem_addr_d = mid_c[ADDR_W-1:0];
      FETCH:   steps_d = steps_q + PW'(1);
      DECIDE: begin
        if (exact_hit_c) begin
          found_d = 1'b1;
          index_d = mem_addr_q;
        end else if (mem_rdata < target_q) begin
          l_d = $signed(addr_ext + PW'(1));
        end else begin
          r_d = $signed(addr_ext - PW'(1));
        end
      end
      RESOLVE: begin
        if (mode_q == MODE_EXACT) begin
          found_d = 1'b0;
          index_d = '0;
        end else begin
          found_d = lb_found_c;
          index_d = lb_found_c ? l_q[ADDR_W-1:0] : '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      l_q        <= '0;
      r_q        <= '0;
      hi_q       <= '0;
      target_q   <= '0;
      mode_q     <= MODE_EXACT;
      mem_addr_q <= '0;
      found_q    <= 1'b0;
      index_q    <= '0;
      steps_q    <= '0;
    end else begin
      l_q        <= l_d;
      r_q        <= r_d;
      hi_q       <= hi_d;
      target_q   <= target_d;
      mode_q     <= mode_d;
      mem_addr_q <= mem_addr_d;
      found_q    <= found_d;
      index_q    <= index_d;
      steps_q    <= steps_d;
    end
  end

  assign found    = found_q;
  assign index    = index_q;
  assign steps    = steps_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: rtl/binary_search_engine.sv
// Binary search over a sorted synchronous-read memory, exact or lower-bound mode.
module binary_search_engine
  import binary_search_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] target,
  input  logic [ADDR_W-1:0] lo,
  input  logic [ADDR_W-1:0] hi,
  output logic              ready,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] index,
  output logic [ADDR_W:0]   steps,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e state;
  logic   l_gt_r_c;
  logic   exact_hit_c;

  binary_search_engine_ctrl #(
    .RD_LAT (RD_LAT)
  ) u_ctrl (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .l_gt_r_c    (l_gt_r_c),
    .exact_hit_c (exact_hit_c),
    .state       (state),
    .ready       (ready),
    .done        (done),
    .mem_rd      (mem_rd)
  );

  binary_search_engine_datapath #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_datapath (
    .clk         (clk),
    .reset_n     (reset_n),
    .state       (state),
    .start       (start),
    .mode        (mode),
    .target      (target),
    .lo          (lo),
    .hi          (hi),
    .mem_rdata   (mem_rdata),
    .l_gt_r_c    (l_gt_r_c),
    .exact_hit_c (exact_hit_c),
    .found       (found),
    .index       (index),
    .steps       (steps),
    .mem_addr    (mem_addr)
  );

endmodule

// File: tb/tb_binary_search_engine.sv
// Bench: three engines (read latency 1, 2, 4) share stimulus and a sorted memory.
module tb_binary_search_engine;

  localparam int NI = 3;
  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          mode;
  logic [DW-1:0] target;
  logic [AW-1:0] lo, hi;

  logic          ready_w    [NI];
  logic          done_w     [NI];
  logic          found_w    [NI];
  logic          mem_rd_w   [NI];
  logic [AW-1:0] index_w    [NI];
  logic [AW-1:0] mem_addr_w [NI];
  logic [AW:0]   steps_w    [NI];
  logic [DW-1:0] mem_rdata_w[NI];

  logic [DW-1:0] mem  [32];
  logic [DW-1:0] pipe [NI][8];

  int tests = 0;
  int fails = 0;

  // model results
  bit exp_found, exp_hit;
  int exp_idx, exp_n;
  int exp_probe [8];

  always #5 clk = ~clk;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    binary_search_engine #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .mode      (mode),
      .target    (target),
      .lo        (lo),
      .hi        (hi),
      .ready     (ready_w[g]),
      .done      (done_w[g]),
      .found     (found_w[g]),
      .index     (index_w[g]),
      .steps     (steps_w[g]),
      .mem_rd    (mem_rd_w[g]),
      .mem_addr  (mem_addr_w[g]),
      .mem_rdata (mem_rdata_w[g])
    );
  end

  // Read pipeline: data appears exactly LAT cycles after the strobe, garbage otherwise.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      pipe[g][0] <= mem_rd_w[g] ? mem[mem_addr_w[g]] : DW'($urandom);
      for (int i = 1; i < 8; i++) pipe[g][i] <= pipe[g][i-1];
    end
  end

  always_comb begin
    for (int g = 0; g < NI; g++) mem_rdata_w[g] = pipe[g][lat_of(g)-1];
  end

  task automatic chk(input string tag, input int g, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s lat=%0d observed=%0d expected=%0d", tag, lat_of(g), obs, expv);
    end
  endtask

  // Reference: textbook binary search for probe order, linear scans for results.
  task automatic model(input bit m, input logic [DW-1:0] t, input int l0, input int h0);
    int l, r, md, bs_idx;
    bit hit;
    l = l0; r = h0; hit = 0; bs_idx = 0; exp_n = 0;
    while (l <= r && !hit) begin
      md = (l + r) / 2;
      if (exp_n < 8) exp_probe[exp_n] = md;
      exp_n++;
      if (m == 1'b0 && mem[md] == t) begin
        hit = 1; bs_idx = md;
      end else if (mem[md] < t) l = md + 1;
      else r = md - 1;
    end
    exp_hit = hit;
    exp_found = 0; exp_idx = 0;
    for (int i = l0; i <= h0; i++) begin
      if (!exp_found) begin
        if (m == 1'b0 && mem[i] == t) begin
          exp_found = 1; exp_idx = bs_idx;
        end else if (m == 1'b1 && mem[i] >= t) begin
          exp_found = 1; exp_idx = i;
        end
      end
    end
  endtask

  // One search on all engines; hold start 5 cycles past the last done, then release.
  task automatic run(input bit m, input logic [DW-1:0] t, input logic [AW-1:0] l, input logic [AW-1:0] h);
    int            done_cyc [NI];
    int            pn       [NI];
    logic [AW-1:0] plog     [NI][8];
    bit            rd_done  [NI];
    bit            unstable [NI];
    logic          hf       [NI];
    logic [AW-1:0] hidx     [NI];
    logic [AW:0]   hsteps   [NI];
    int            maxd;
    bit            all_done;
    int            lat_exp;
    model(m, t, int'(l), int'(h));
    @(negedge clk);
    start = 1'b1; mode = m; target = t; lo = l; hi = h;
    for (int g = 0; g < NI; g++) begin
      done_cyc[g] = 0; pn[g] = 0; rd_done[g] = 0; unstable[g] = 0;
    end
    for (int c = 1; c <= 250; c++) begin
      @(negedge clk);
      all_done = 1; maxd = 0;
      for (int g = 0; g < NI; g++) begin
        if (c == 1) chk("ready_fall", g, 32'(ready_w[g]), 32'd0);
        if (mem_rd_w[g]) begin
          if (done_w[g]) rd_done[g] = 1;
          if (pn[g] < 8) plog[g][pn[g]] = mem_addr_w[g];
          pn[g]++;
        end
        if (done_w[g]) begin
          if (done_cyc[g] == 0) begin
            done_cyc[g] = c; hf[g] = found_w[g]; hidx[g] = index_w[g]; hsteps[g] = steps_w[g];
          end else if (found_w[g] !== hf[g] || index_w[g] !== hidx[g] || steps_w[g] !== hsteps[g]) begin
            unstable[g] = 1;
          end
        end else if (done_cyc[g] != 0) begin
          unstable[g] = 1;
        end
        if (done_cyc[g] == 0) all_done = 0;
        if (done_cyc[g] > maxd) maxd = done_cyc[g];
      end
      if (all_done && c >= maxd + 5) break;
    end
    for (int g = 0; g < NI; g++) begin
      // done is first seen in the cycle after the final DECIDE (hit)
      // or after the closing COMPUTE/RESOLVE pair (miss, lower bound, empty)
      lat_exp = exp_n * (lat_of(g) + 2) + ((m == 1'b0 && exp_hit) ? 1 : 3);
      chk("latency", g, 32'(done_cyc[g]), 32'(lat_exp));
      chk("found", g, 32'(hf[g]), 32'(exp_found));
      chk("index", g, 32'(hidx[g]), 32'(exp_idx));
      chk("steps", g, 32'(hsteps[g]), 32'(exp_n));
      chk("probe_count", g, 32'(pn[g]), 32'(exp_n));
      for (int i = 0; i < exp_n && i < pn[g] && i < 8; i++)
        chk("probe_addr", g, 32'(plog[g][i]), 32'(exp_probe[i]));
      chk("rd_in_done", g, 32'(rd_done[g]), 32'd0);
      chk("held_stable", g, 32'(unstable[g]), 32'd0);
    end
    start = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk("ready_back", g, 32'(ready_w[g]), 32'd1);
      chk("done_drop", g, 32'(done_w[g]), 32'd0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int g = 0; g < NI; g++) begin
      chk({tag, "_ready"}, g, 32'(ready_w[g]), 32'd1);
      chk({tag, "_done"}, g, 32'(done_w[g]), 32'd0);
      chk({tag, "_found"}, g, 32'(found_w[g]), 32'd0);
      chk({tag, "_index"}, g, 32'(index_w[g]), 32'd0);
      chk({tag, "_steps"}, g, 32'(steps_w[g]), 32'd0);
      chk({tag, "_mem_rd"}, g, 32'(mem_rd_w[g]), 32'd0);
      chk({tag, "_mem_addr"}, g, 32'(mem_addr_w[g]), 32'd0);
    end
  endtask

  task automatic fill_linear();
    for (int i = 0; i < 32; i++) mem[i] = DW'(4 * i);
  endtask

  initial begin
    int v;
    logic [AW-1:0] rl, rh;
    logic [DW-1:0] rt;
    reset_n = 1'b0; start = 1'b0; mode = 1'b0; target = '0; lo = '0; hi = '0;
    fill_linear();
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    reset_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_reset");

    // directed: memory mem[i] = 4*i
    run(1'b0, 8'd100, 5'd0, 5'd31);   // exact hit at 25
    run(1'b0, 8'd101, 5'd0, 5'd31);   // exact miss
    run(1'b1, 8'd101, 5'd0, 5'd31);   // lower bound -> 26
    run(1'b1, 8'd0,   5'd0, 5'd31);   // lower bound -> 0
    run(1'b1, 8'd200, 5'd0, 5'd31);   // lower bound past end
    run(1'b0, 8'd20,  5'd5, 5'd4);    // empty window, exact
    run(1'b1, 8'd20,  5'd5, 5'd4);    // empty window, lower bound
    run(1'b0, 8'd124, 5'd31, 5'd31);  // single-entry window at top
    run(1'b1, 8'd125, 5'd20, 5'd31);  // lower bound beyond a sub-window

    // duplicates: mem[9..12] = 40
    for (int i = 9; i <= 12; i++) mem[i] = 8'd40;
    run(1'b1, 8'd40, 5'd0, 5'd31);    // first duplicate -> 9
    run(1'b0, 8'd40, 5'd0, 5'd31);

    // asynchronous reset while the RD_LAT=2 engine sits in WAIT
    fill_linear();
    @(negedge clk);
    start = 1'b1; mode = 1'b0; target = 8'd100; lo = 5'd0; hi = 5'd31;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run(1'b0, 8'd100, 5'd0, 5'd31);

    // randomized sorted memories, windows and targets
    for (int n = 0; n < 16; n++) begin
      v = int'($urandom_range(0, 5));
      for (int i = 0; i < 32; i++) begin
        mem[i] = DW'(v);
        v = v + int'($urandom_range(0, 7));
      end
      rl = AW'($urandom_range(0, 31));
      rh = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(int'(rl), 31));
      rt = ($urandom_range(0, 1) == 0) ? mem[$urandom_range(0, 31)] : DW'($urandom);
      run(1'($urandom_range(0, 1)), rt, rl, rh);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
